approx_add_sched: RTL and testbench
===================================

// Module: approx_add_sched
// PURPOSE
//  Shares one 32-bit configurable-approximation adder among NUM_REQ requesters.
//  Each requester's adder has a programmable number of low bits built from approximate mirror cells.
//  In those bits Cout = majority and Sum = ~Cout; the remaining upper bits use exact full adders.
//  Round-robin arbitration, valid/ready handshakes, one registered result per cycle, output backpressure.
// PARAMETERS
//  NUM_REQ   4    number of requesters (>=2)
//  WIDTH     32   operand/result width
//  LVL_W     6    level field width, $clog2(WIDTH+1); level = count of approximate LSBs
// PORTS
//  clock        in   1              single clock, rising edge
//  reset_N      in   1              asynchronous, active-low reset
//  req_valid    in   NUM_REQ        requester i has an operand pair
//  req_ready    out  NUM_REQ        one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_a        in   NUM_REQ*WIDTH  operand A, requester i in [i*WIDTH +: WIDTH]
//  req_b        in   NUM_REQ*WIDTH  operand B, same packing
//  cfg_we       in   1              write approximation level
//  cfg_id       in   $clog2(NUM_REQ) requester whose level is written
//  cfg_level    in   LVL_W          new level; values > WIDTH clamp to WIDTH
//  res_valid    out  1              result register holds a result
//  res_ready    in   1              consumer accepts result
//  res_sum      out  WIDTH          result sum
//  res_cout     out  1              carry out of bit WIDTH-1
//  res_id       out  $clog2(NUM_REQ) requester that produced the result
//  res_level    out  LVL_W          level used for the result
// BEHAVIOUR
//  Reset, asynchronous:
//   - res_valid=0; res_sum, res_cout, res_id and res_level are 0.
//   - RR pointer=0; every level register=0 (exact addition).
//  Arbitration, combinational:
//   - Grant only when the slot is free: !res_valid | res_ready.
//   - Search starts at the pointer, wrapping modulo NUM_REQ; the first requester with req_valid set gets req_ready.
//   - No slot free, or no requester valid: req_ready = 0.
//   - req_ready never asserts for a requester whose req_valid is low.
//  Grant cycle:
//   - The pointer moves to (granted+1) mod NUM_REQ.
//   - Otherwise the pointer holds.
//  Datapath, k = level[granted], Cin = 0, bits computed LSB first:
//   - Bit i < k: c[i+1] = maj(a_i, b_i, c_i); s_i = ~c[i+1].
//   - Bit i >= k: s_i = a_i ^ b_i ^ c_i; c[i+1] = maj(a_i, b_i, c_i).
//   - res_cout = c[WIDTH].
//   - k = 0 gives exact addition mod 2^WIDTH.
//  Latency: 1 cycle. A grant at edge N gives res_valid=1 after edge N with the captured sum, id and level.
//  Result register:
//   - Holds all fields while res_valid & !res_ready.
//   - Clears to res_valid=0 on res_ready when there is no new grant.
//   - Accept and grant in the same cycle: the new result replaces the old one, giving full throughput.
//  Configuration:
//   - A cfg_we write takes effect from the next cycle.
//   - Write and grant to the same id in one cycle: the grant uses the old level.
//   - Writes are accepted regardless of backpressure.
//  Reset mid-operation: any held result is discarded; no partial state survives.
// TESTING
//  1. Reset, levels 0; req0 a=0xFFFFFFFF, b=1 -> next cycle res_sum=0, res_cout=1, res_id=0, res_level=0.
//  2. cfg req1 level=32; req1 a=0, b=0 -> res_sum=0xFFFFFFFF, res_cout=0.
//     Then level=4, a=0, b=0 -> res_sum=0x0000000F.
//     Level=2, a=3, b=0 -> res_sum=3.
//  3. All 4 req_valid held high, res_ready=1 -> one grant per cycle, ids 0,1,2,3,0,1; res_valid stays 1.
//  4. res_ready=0 for 3 cycles with a result held -> res_* stable, req_ready=0.
//     Raise res_ready -> the next id grants in that same cycle.
//  5. cfg_we for id 2 (level 8) in the same cycle as a grant to 2 -> that result has res_level=0.
//     The next grant to 2 has res_level=8.
//  6. Drop reset_N while res_valid=1 -> res_valid=0 at once.
//     After reset, requester 3 previously at level 8: a=0, b=0 gives 0 (level back to 0).

Source files
------------

// File: rtl/approx_add_sched.sv
// approx_add_sched: round-robin shared 32-bit adder with per-requester count of approximate mirror-cell LSBs
module approx_add_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LVL_W   = $clog2(WIDTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset_N,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_REQ)-1:0] cfg_id,
  input  logic [LVL_W-1:0]           cfg_level,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_sum,
  output logic                       res_cout,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [LVL_W-1:0]           res_level
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [ID_W-1:0]  ptr_q, ptr_d, gnt_id, idx;
  logic             gnt, c, m;
  logic [LVL_W-1:0] lvl_q [NUM_REQ];
  logic [LVL_W-1:0] lvl_d [NUM_REQ];
  logic [LVL_W-1:0] k, cfg_clamp;
  logic [WIDTH-1:0] a_sel, b_sel, sum;
  logic             res_valid_q, res_valid_d, res_cout_q, res_cout_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [LVL_W-1:0] res_level_q, res_level_d;

  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    idx = '0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = ID_W'((int'(ptr_q) + j) % NUM_REQ);
      if (!gnt && req_valid[idx] && (!res_valid_q || res_ready)) begin
        gnt = 1'b1;
        gnt_id = idx;
      end
    end
    if (gnt) req_ready[gnt_id] = 1'b1;
    ptr_d = gnt ? ((int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
  end

  // Carry chain is a majority chain everywhere; only the sum cell differs below k.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (gnt_id == ID_W'(n)) begin
        a_sel = req_a[n*WIDTH +: WIDTH];
        b_sel = req_b[n*WIDTH +: WIDTH];
      end
    end
    k = lvl_q[gnt_id];
    c = 1'b0;
    m = 1'b0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m = (a_sel[i] & b_sel[i]) | (a_sel[i] & c) | (b_sel[i] & c);
      sum[i] = (LVL_W'(i) < k) ? ~m : a_sel[i] ^ b_sel[i] ^ c;
      c = m;
    end
  end

  always_comb begin
    cfg_clamp = (cfg_level > LVL_W'(WIDTH)) ? LVL_W'(WIDTH) : cfg_level;
    for (int n = 0; n < NUM_REQ; n++)
      lvl_d[n] = (cfg_we && int'(cfg_id) == n) ? cfg_clamp : lvl_q[n];
    res_valid_d = gnt | (res_valid_q & ~res_ready);
    res_sum_d   = gnt ? sum : res_sum_q;
    res_cout_d  = gnt ? c : res_cout_q;
    res_id_d    = gnt ? gnt_id : res_id_q;
    res_level_d = gnt ? k : res_level_q;
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      res_level_q <= '0;
      for (int n = 0; n < NUM_REQ; n++) lvl_q[n] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
      res_level_q <= res_level_d;
      for (int n = 0; n < NUM_REQ; n++) lvl_q[n] <= lvl_d[n];
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign res_level = res_level_q;
endmodule

// File: tb/tb_approx_add_sched.sv
// tb_approx_add_sched: scoreboard bench with an arithmetic reference model of the approximate adder
module tb_approx_add_sched;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 6;

  logic            clock = 1'b0;
  logic            reset_N;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*W-1:0]  req_a, req_b;
  logic            cfg_we;
  logic [1:0]      cfg_id;
  logic [LW-1:0]   cfg_level;
  logic            res_valid, res_ready, res_cout;
  logic [W-1:0]    res_sum;
  logic [1:0]      res_id;
  logic [LW-1:0]   res_level;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          cout;
    logic [1:0]    id;
    logic [LW-1:0] lvl;
  } res_t;

  res_t exp_q[$];
  int   compared = 0, mismatched = 0;
  int   m_ptr, m_lvl[N];
  logic m_valid;

  approx_add_sched #(.NUM_REQ(N), .WIDTH(W), .LVL_W(LW)) dut (
    .clock(clock), .reset_N(reset_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_level(cfg_level),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .res_level(res_level)
  );

  always #5 clock = ~clock;

  // Carries are those of exact addition; approximate bits are the inverted carry-out of each bit.
  function automatic res_t model_add(logic [W-1:0] a, logic [W-1:0] b, int k, int id);
    res_t r;
    logic [W:0] full, carries, mask;
    full    = {1'b0, a} + {1'b0, b};
    carries = full ^ {1'b0, a} ^ {1'b0, b};
    mask    = ((W+1)'(1) << k) - (W+1)'(1);
    r.sum   = (full[W-1:0] & ~mask[W-1:0]) | (~carries[W:1] & mask[W-1:0]);
    r.cout  = full[W];
    r.id    = 2'(id);
    r.lvl   = LW'(k);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 0;
    m_valid = 1'b0;
    for (int i = 0; i < N; i++) m_lvl[i] = 0;
  endtask

  task automatic idle();
    req_valid = '0;
    cfg_we = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_valid[i[1:0]] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic set_cfg(int id, int lvl);
    cfg_we = 1'b1;
    cfg_id = 2'(id);
    cfg_level = LW'(lvl);
  endtask

  // Inputs are set right after a falling edge; this predicts the next rising edge.
  task automatic cycle();
    int g;
    int idx;
    logic [N-1:0] exp_rdy;
    #1;
    check("res_valid", 64'(res_valid), 64'(m_valid));
    g = -1;
    if (!m_valid || res_ready)
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr + j) % N;
        if (g < 0 && req_valid[idx[1:0]]) g = idx;
      end
    exp_rdy = (g >= 0) ? N'(1) << g : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      exp_q.push_back(model_add(W'(req_a >> (g*W)), W'(req_b >> (g*W)), m_lvl[g], g));
      m_ptr = (g + 1) % N;
    end
    m_valid = (g >= 0) || (m_valid && !res_ready);
    if (cfg_we) m_lvl[cfg_id] = (int'(cfg_level) > W) ? W : int'(cfg_level);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset_N = 1'b0;
    #1;
    check("reset_res_valid", 64'(res_valid), 64'(0));
    model_reset();
    repeat (2) @(negedge clock);
    reset_N = 1'b1;
  endtask

  logic        held = 1'b0;
  logic [63:0] held_v;
  initial forever begin
    res_t e;
    @(negedge clock);
    #2;
    if (reset_N) begin
      if (held) check("hold_stable", 64'({res_valid, res_sum, res_cout, res_id, res_level}), held_v);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got id %0d sum 0x%0h expected none", res_id, res_sum);
        end else begin
          e = exp_q.pop_front();
          check("res_sum", 64'(res_sum), 64'(e.sum));
          check("res_cout", 64'(res_cout), 64'(e.cout));
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_level", 64'(res_level), 64'(e.lvl));
        end
      end
      held = res_valid && !res_ready;
      held_v = 64'({res_valid, res_sum, res_cout, res_id, res_level});
    end else held = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_N = 1'b0;
    req_a = '0;
    req_b = '0;
    cfg_id = '0;
    cfg_level = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_sum", 64'(res_sum), 64'(0));
    check("rst_cout", 64'(res_cout), 64'(0));
    check("rst_id", 64'(res_id), 64'(0));
    check("rst_level", 64'(res_level), 64'(0));
    reset_N = 1'b1;
    @(negedge clock);

    set_req(0, 32'hFFFF_FFFF, 32'h1); cycle();
    idle(); cycle();

    set_cfg(1, 32); cycle();
    idle(); set_req(1, 0, 0); cycle();
    idle(); set_cfg(1, 4); cycle();
    idle(); set_req(1, 0, 0); cycle();
    idle(); set_cfg(1, 2); cycle();
    idle(); set_req(1, 3, 0); cycle();
    idle(); set_cfg(0, 63); cycle();
    idle(); set_req(0, 32'h1234_5678, 32'h0F0F_F0F0); cycle();
    idle(); cycle();

    do_reset();
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
    repeat (6) cycle();
    res_ready = 1'b0;
    repeat (3) cycle();
    res_ready = 1'b1;
    repeat (2) cycle();

    idle(); cycle();
    set_req(2, 32'h00FF_00FF, 32'h0F0F_0F0F); set_cfg(2, 8); cycle();
    idle(); set_req(2, 32'h00FF_00FF, 32'h0F0F_0F0F); cycle();
    idle(); cycle();

    set_cfg(3, 8); cycle();
    idle(); set_req(3, 32'hAAAA_5555, 32'h1); res_ready = 1'b0; cycle();
    do_reset();
    set_req(3, 0, 0); cycle();
    idle(); cycle();

    for (int t = 0; t < 400; t++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[i*W +: W] = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      end
      res_ready = ($urandom % 4) != 0;
      cfg_we = ($urandom % 5) == 0;
      cfg_id = 2'($urandom);
      cfg_level = LW'($urandom_range(0, 63));
      cycle();
    end
    idle();
    repeat (4) cycle();
    #3;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
